bin2bcd_seq: RTL

- Iterative shift-add-3 (double-dabble) binary-to-BCD converter. Sits between the free-running event counter and the paged 7-segment display mux.
- Converts one WIDTH-bit unsigned value into DIGITS packed BCD digits, one bit per clock, using a start/busy/done handshake.
- Holds the last result stable so the slow-clock display pager can sample it at any time.
- Flags values too large for DIGITS digits and blanks the output with 4'hF codes, which the BCD-to-7-segment decoder displays as blank.

---
 rtl/bin2bcd_seq.sv | 114 +++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one input bit per clock,
// start/busy/done handshake, result held until the next conversion completes.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | one adjust-and-shift iteration per clock, WIDTH iterations
// DONE  | single cycle with done high; new result visible
module bin2bcd_seq #(
    parameter int WIDTH  = 36,
    parameter int DIGITS = 11
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                overflow
);
    localparam int AW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [AW-1:0]    acc_q, acc_d, acc_adj;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [AW-1:0]    bcd_q, bcd_d;
    logic             ovf_out_q, ovf_out_d;

    // Per-digit add-3 correction; digits never carry into each other here.
    always_comb begin
        acc_adj = acc_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        bcd_d     = bcd_q;
        ovf_out_d = ovf_out_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = bin_in;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = {acc_adj[AW-2:0], sr_q[WIDTH-1]};
                sr_d  = sr_q << 1;
                // A set MSB leaving the top digit means the value needs one more digit.
                ovf_d = ovf_q | acc_adj[AW-1];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d   = DONE;
                    bcd_d     = ovf_d ? {DIGITS{4'hF}} : acc_d;
                    ovf_out_d = ovf_d;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            bcd_q     <= bcd_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign bcd_out  = bcd_q;
    assign overflow = ovf_out_q;

endmodule
